// File: rtl/regression_pkg.sv
// rtl/regression_pkg.sv - shared widths, run length and FSM state encoding for the sample feeder
// Purpose: default DATA_W/N/ADDR_W and the feeder state enumeration.
// Ports: none (package).
package regression_pkg;

  localparam int DATA_W = 20;   // sample width
  localparam int N      = 150;  // samples per run
  localparam int ADDR_W = 8;    // index width, N <= 2**ADDR_W

  typedef enum logic [2:0] {
    IDLE,
    LAUNCH,
    PASS1,
    WAIT_MEANS,
    PASS2,
    WAIT_DONE,
    DONE
  } state_t;

  function automatic logic is_pass_state(state_t s);
    return (s == PASS1) || (s == PASS2);
  endfunction

endpackage

// File: rtl/sample_feeder_if.sv
// rtl/sample_feeder_if.sv - write, run-control and sample-serving signals between control side and feeder
// Purpose: bundles every non-clock/reset signal of sample_feeder.
// Ports (master = control side / bench, slave = sample_feeder):
//   master drives wr_en, wr_addr, wr_x, wr_y, start, ldx, ldy, mean_ready, all_ready
//   slave drives  en, co, x_out, y_out, pass, busy, done, err
interface sample_feeder_if #(
  parameter int DATA_W = regression_pkg::DATA_W,
  parameter int ADDR_W = regression_pkg::ADDR_W
);

  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_x;
  logic [DATA_W-1:0] wr_y;
  logic              start;
  logic              ldx;
  logic              ldy;
  logic              mean_ready;
  logic              all_ready;
  logic              en;
  logic              co;
  logic [DATA_W-1:0] x_out;
  logic [DATA_W-1:0] y_out;
  logic              pass;
  logic              busy;
  logic              done;
  logic              err;

  modport master (
    output wr_en, wr_addr, wr_x, wr_y, start, ldx, ldy, mean_ready, all_ready,
    input  en, co, x_out, y_out, pass, busy, done, err
  );

  modport slave (
    input  wr_en, wr_addr, wr_x, wr_y, start, ldx, ldy, mean_ready, all_ready,
    output en, co, x_out, y_out, pass, busy, done, err
  );

endinterface

// File: rtl/sample_ram.sv
// rtl/sample_ram.sv - sample storage, one synchronous write port and one synchronous read port
// Purpose: 2**ADDR_W words of {x, y}; contents are never reset.
// Ports: clk, wr_en_i/wr_addr_i/wr_data_i (write), rd_addr_i/rd_data_o (registered read).
module sample_ram #(
  parameter int DATA_W = 20,
  parameter int ADDR_W = 8
) (
  input  logic                clk,
  input  logic                wr_en_i,
  input  logic [ADDR_W-1:0]   wr_addr_i,
  input  logic [2*DATA_W-1:0] wr_data_i,
  input  logic [ADDR_W-1:0]   rd_addr_i,
  output logic [2*DATA_W-1:0] rd_data_o
);

  logic [2*DATA_W-1:0] mem_q [0:(1<<ADDR_W)-1];
  logic [2*DATA_W-1:0] rd_q;

  // Read-before-write: a word written at an edge is visible one edge later.
  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
    rd_q <= mem_q[rd_addr_i];
  end

  assign rd_data_o = rd_q;

endmodule

// File: rtl/sample_feeder.sv
// rtl/sample_feeder.sv - serves stored (x, y) pairs to the coefficient control unit over two passes
// Purpose: run FSM, sample index, served-sample registers and protocol-error flag.
// Ports: clk, rst (sync, active-low), bus (sample_feeder_if.slave: writes, start,
//        load strobes, control-unit status in; en, co, x_out, y_out, pass, busy, done, err out).
module sample_feeder #(
  parameter int DATA_W = regression_pkg::DATA_W,
  parameter int N      = regression_pkg::N,
  parameter int ADDR_W = regression_pkg::ADDR_W
) (
  input  logic             clk,
  input  logic             rst,
  sample_feeder_if.slave   bus
);

  import regression_pkg::*;

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(N - 1);

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   idx_q, idx_d;
  logic [DATA_W-1:0]   x_q, x_d, y_q, y_d;
  logic                co_q, co_d;
  logic                pass_q, pass_d;
  logic                err_q, err_d;
  logic [2*DATA_W-1:0] rd_data;
  logic                in_pass;
  logic                serve;

  // Read address follows the next index so rd_data always holds mem[idx_q];
  // back-to-back strobes then each see the word they are meant to serve.
  sample_ram #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk       (clk),
    .wr_en_i   (bus.wr_en && (state_q == IDLE)),
    .wr_addr_i (bus.wr_addr),
    .wr_data_i ({bus.wr_x, bus.wr_y}),
    .rd_addr_i (idx_d),
    .rd_data_o (rd_data)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      x_q     <= '0;
      y_q     <= '0;
      co_q    <= 1'b0;
      pass_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      x_q     <= x_d;
      y_q     <= y_d;
      co_q    <= co_d;
      pass_q  <= pass_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    x_d     = x_q;
    y_d     = y_q;
    co_d    = co_q;
    pass_d  = pass_q;
    err_d   = err_q;
    in_pass = is_pass_state(state_q);
    serve   = in_pass && bus.ldx && bus.ldy;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = LAUNCH;
          err_d   = 1'b0;
          idx_d   = '0;
        end
      end
      LAUNCH: begin
        state_d = PASS1;
        pass_d  = 1'b0;
      end
      PASS1: begin
        if (serve && (idx_q == LAST)) state_d = WAIT_MEANS;
      end
      WAIT_MEANS: begin
        if (bus.mean_ready) begin
          state_d = PASS2;
          pass_d  = 1'b1;
        end
      end
      PASS2: begin
        if (serve && (idx_q == LAST)) state_d = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (bus.all_ready) state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // co drops on any strobe or state change; a serve overrides that below.
    if (bus.ldx || bus.ldy || (state_d != state_q)) co_d = 1'b0;

    if (serve) begin
      x_d   = rd_data[2*DATA_W-1:DATA_W];
      y_d   = rd_data[DATA_W-1:0];
      co_d  = (idx_q == LAST);
      idx_d = (idx_q == LAST) ? '0 : idx_q + ADDR_W'(1);
    end

    if (in_pass && (bus.ldx != bus.ldy)) err_d = 1'b1;
  end

  assign bus.en    = (state_q == LAUNCH);
  assign bus.done  = (state_q == DONE);
  assign bus.busy  = (state_q != IDLE);
  assign bus.co    = co_q;
  assign bus.x_out = x_q;
  assign bus.y_out = y_q;
  assign bus.pass  = pass_q;
  assign bus.err   = err_q;

endmodule

// File: tb/tb_sample_feeder.sv
// tb/tb_sample_feeder.sv - scoreboard bench for sample_feeder with N=4
module tb_sample_feeder;

  localparam int DW = 20;
  localparam int AW = 8;

  typedef struct {
    logic [DW-1:0] x;
    logic [DW-1:0] y;
    logic          co;
  } exp_t;

  logic clk;
  logic rst;
  logic pend;
  int   n_cmp;
  int   n_bad;
  exp_t sb_q[$];

  sample_feeder_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

  sample_feeder #(.DATA_W(DW), .N(4), .ADDR_W(AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic serve(input int x, input int y, input logic co);
    exp_t e;
    e.x = DW'(x);
    e.y = DW'(y);
    e.co = co;
    sb_q.push_back(e);
    bus.ldx = 1'b1;
    bus.ldy = 1'b1;
    tick();
    bus.ldx = 1'b0;
    bus.ldy = 1'b0;
  endtask

  // Monitor: a served sample appears on the edge that saw both strobes high.
  always @(posedge clk) pend <= bus.ldx && bus.ldy;

  always @(negedge clk) begin
    if (pend) begin
      if (sb_q.size() == 0) begin
        check("sb_unexpected_serve", 64'd1, 64'd0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("x_out", 64'(bus.x_out), 64'(e.x));
        check("y_out", 64'(bus.y_out), 64'(e.y));
        check("co", 64'(bus.co), 64'(e.co));
      end
    end
  end

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst = 1'b0;
    bus.wr_en = 1'b0;
    bus.wr_addr = '0;
    bus.wr_x = '0;
    bus.wr_y = '0;
    bus.start = 1'b0;
    bus.ldx = 1'b0;
    bus.ldy = 1'b0;
    bus.mean_ready = 1'b0;
    bus.all_ready = 1'b0;
    tick();
    tick();
    check("rst_en", 64'(bus.en), 64'd0);
    check("rst_co", 64'(bus.co), 64'd0);
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_done", 64'(bus.done), 64'd0);
    check("rst_err", 64'(bus.err), 64'd0);
    check("rst_pass", 64'(bus.pass), 64'd0);
    check("rst_x", 64'(bus.x_out), 64'd0);
    check("rst_y", 64'(bus.y_out), 64'd0);
    rst = 1'b1;

    for (int i = 0; i < 4; i++) begin
      bus.wr_en = 1'b1;
      bus.wr_addr = AW'(i);
      bus.wr_x = DW'(i + 1);
      bus.wr_y = DW'(2 * (i + 1));
      tick();
    end
    bus.wr_en = 1'b0;

    // Run A: both passes and done
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    check("a_en_high", 64'(bus.en), 64'd1);
    check("a_busy", 64'(bus.busy), 64'd1);
    tick();
    check("a_en_low", 64'(bus.en), 64'd0);
    check("a_pass0", 64'(bus.pass), 64'd0);
    serve(1, 2, 1'b0);
    serve(2, 4, 1'b0);
    tick();
    serve(3, 6, 1'b0);
    serve(4, 8, 1'b1);
    tick();
    check("a_co_hold", 64'(bus.co), 64'd1);
    bus.mean_ready = 1'b1;
    tick();
    bus.mean_ready = 1'b0;
    check("a_pass1", 64'(bus.pass), 64'd1);
    check("a_co_clr", 64'(bus.co), 64'd0);
    serve(1, 2, 1'b0);
    serve(2, 4, 1'b0);
    serve(3, 6, 1'b0);
    serve(4, 8, 1'b1);
    bus.all_ready = 1'b1;
    tick();
    bus.all_ready = 1'b0;
    check("a_done", 64'(bus.done), 64'd1);
    check("a_busy_in_done", 64'(bus.busy), 64'd1);
    tick();
    check("a_done_low", 64'(bus.done), 64'd0);
    check("a_busy_low", 64'(bus.busy), 64'd0);

    // Run B: ignored start/write while busy, protocol error, mid-run reset
    bus.start = 1'b1;
    tick();
    check("b_en", 64'(bus.en), 64'd1);
    bus.wr_en = 1'b1;
    bus.wr_addr = '0;
    bus.wr_x = DW'(99);
    bus.wr_y = DW'(99);
    tick();
    bus.wr_en = 1'b0;
    bus.start = 1'b0;
    check("b_no_relaunch", 64'(bus.en), 64'd0);
    serve(1, 2, 1'b0);
    serve(2, 4, 1'b0);
    bus.ldx = 1'b1;
    tick();
    bus.ldx = 1'b0;
    check("b_err", 64'(bus.err), 64'd1);
    check("b_x_hold", 64'(bus.x_out), 64'd2);
    serve(3, 6, 1'b0);
    serve(4, 8, 1'b1);
    bus.mean_ready = 1'b1;
    tick();
    bus.mean_ready = 1'b0;
    check("b_err_sticky", 64'(bus.err), 64'd1);
    serve(1, 2, 1'b0);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    check("mr_busy", 64'(bus.busy), 64'd0);
    check("mr_done", 64'(bus.done), 64'd0);
    check("mr_err", 64'(bus.err), 64'd0);
    check("mr_pass", 64'(bus.pass), 64'd0);
    check("mr_x", 64'(bus.x_out), 64'd0);
    check("mr_y", 64'(bus.y_out), 64'd0);
    check("mr_co", 64'(bus.co), 64'd0);

    // Run C: no rewrite of index 0; write of index 3 together with start
    bus.start = 1'b1;
    bus.wr_en = 1'b1;
    bus.wr_addr = AW'(3);
    bus.wr_x = DW'(40);
    bus.wr_y = DW'(80);
    tick();
    bus.start = 1'b0;
    bus.wr_en = 1'b0;
    check("c_en", 64'(bus.en), 64'd1);
    tick();
    serve(1, 2, 1'b0);
    serve(2, 4, 1'b0);
    serve(3, 6, 1'b0);
    serve(40, 80, 1'b1);

    for (int i = 0; i < 20 && sb_q.size() != 0; i++) tick();
    check("sb_drained", 64'(sb_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
